// File: rtl/matrix_uart_sequencer_if.sv
// ---------------------------------------------------------------------------
// matrix_uart_sequencer_if
//
// Purpose: bundles every non-clock/reset signal of matrix_uart_sequencer.
//   master modport : the sequencer itself
//   slave modport  : the surrounding logic (UART RX/TX, matrix core, GPIO)
//
// Signals:
//   rx_valid/rx_data      one-cycle strobe plus received UART byte
//   mat_start/mat_data    start pulse and packed elements (elem i at [8i+7:8i])
//   mat_done/mat_result   completion strobe and result from the matrix core
//   gpio_result/valid     last completed result, held
//   tx_valid/tx_data/rdy  byte stream towards the UART transmitter
//   busy/err_timeout      status; drop_cnt saturating count of dropped bytes
// ---------------------------------------------------------------------------
interface matrix_uart_sequencer_if #(
  parameter int N_ELEM   = 4,
  parameter int RESULT_W = 32
);
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  mat_start;
  logic [8*N_ELEM-1:0]   mat_data;
  logic                  mat_done;
  logic [RESULT_W-1:0]   mat_result;
  logic [RESULT_W-1:0]   gpio_result;
  logic                  gpio_valid;
  logic                  tx_valid;
  logic [7:0]            tx_data;
  logic                  tx_ready;
  logic                  busy;
  logic                  err_timeout;
  logic [7:0]            drop_cnt;

  modport master (
    input  rx_valid, rx_data, mat_done, mat_result, tx_ready,
    output mat_start, mat_data, gpio_result, gpio_valid,
           tx_valid, tx_data, busy, err_timeout, drop_cnt
  );

  modport slave (
    output rx_valid, rx_data, mat_done, mat_result, tx_ready,
    input  mat_start, mat_data, gpio_result, gpio_valid,
           tx_valid, tx_data, busy, err_timeout, drop_cnt
  );
endinterface

// File: rtl/matrix_uart_sequencer.sv
// ---------------------------------------------------------------------------
// matrix_uart_sequencer
//
// Purpose: collects N_ELEM bytes from the UART RX stream, starts the matrix
// core once, waits for its completion, latches the result onto the GPIO bus
// and sends it back over UART TX, least significant byte first.
//
// Ports:
//   sys_clk  system clock, all logic on the rising edge
//   rst_n    synchronous active-low reset
//   bus      matrix_uart_sequencer_if.master (RX bytes, matrix core
//            handshake, GPIO result, TX bytes, status)
//
// Optional feature: define MATRIX_SEQ_TIMEOUT_EN to build the inter-byte
// timeout in LOAD (err_timeout pulses and the partial load is discarded).
// Without it LOAD waits indefinitely and err_timeout is constant 0.
// ---------------------------------------------------------------------------
module matrix_uart_sequencer #(
  parameter int N_ELEM      = 4,
  parameter int RESULT_W    = 32,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                    sys_clk,
  input  logic                    rst_n,
  matrix_uart_sequencer_if.master bus
);
  localparam int N_BYTES    = RESULT_W / 8;
  localparam int IDX_W      = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
  localparam int BYTE_IDX_W = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [IDX_W-1:0]      LAST_ELEM = IDX_W'(N_ELEM - 1);
  localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(N_BYTES - 1);

  if (N_ELEM < 1 || N_ELEM > 16 || RESULT_W < 8 || (RESULT_W % 8) != 0 ||
      TIMEOUT_CYC < 1) begin : g_bad_param
    $error("matrix_uart_sequencer: illegal parameter combination");
  end

  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_START, ST_WAIT, ST_REPORT} state_t;

  state_t                state_reg, state_next;
  logic [IDX_W-1:0]      elem_idx_reg;
  logic [BYTE_IDX_W-1:0] byte_idx_reg;
  logic [RESULT_W-1:0]   result_reg;
  logic                  result_valid_reg;
  logic [7:0]            drop_cnt_reg;
  logic [7:0]            result_byte [N_BYTES];
  logic                  timeout_hit;
  logic                  elem_we;
  logic [IDX_W-1:0]      elem_waddr;
  logic                  rx_drop;

  genvar gi;

  // Element storage is never cleared between jobs; each job rewrites all slots.
  for (gi = 0; gi < N_ELEM; gi++) begin : g_elem
    logic [7:0] elem_reg;
    always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
        elem_reg <= 8'h00;
      end else if (elem_we && elem_waddr == IDX_W'(gi)) begin
        elem_reg <= bus.rx_data;
      end
    end
    assign bus.mat_data[8*gi +: 8] = elem_reg;
  end

  for (gi = 0; gi < N_BYTES; gi++) begin : g_byte
    assign result_byte[gi] = result_reg[8*gi +: 8];
  end

`ifdef MATRIX_SEQ_TIMEOUT_EN
  localparam int TO_W = ($clog2(TIMEOUT_CYC) > 0) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TO_W-1:0] to_cnt_reg;

  // Counts idle LOAD cycles; zero on entry to LOAD and on every byte, so a
  // byte arriving in the expiry cycle wins and restarts the count.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      to_cnt_reg <= '0;
    end else if (state_reg != ST_LOAD || bus.rx_valid) begin
      to_cnt_reg <= '0;
    end else begin
      to_cnt_reg <= to_cnt_reg + 1'b1;
    end
  end

  assign timeout_hit = (to_cnt_reg == TO_W'(TIMEOUT_CYC - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    bus.mat_start   = 1'b0;
    bus.tx_valid    = 1'b0;
    bus.tx_data     = 8'h00;
    bus.busy        = 1'b1;
    bus.err_timeout = 1'b0;
    elem_we         = 1'b0;
    elem_waddr      = elem_idx_reg;
    rx_drop         = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        bus.busy = 1'b0;
        if (bus.rx_valid) begin
          elem_we    = 1'b1;
          elem_waddr = '0;
          state_next = (N_ELEM == 1) ? ST_START : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (bus.rx_valid) begin
          elem_we = 1'b1;
          if (elem_idx_reg == LAST_ELEM) state_next = ST_START;
        end else if (timeout_hit) begin
          bus.err_timeout = 1'b1;
          state_next      = ST_IDLE;
        end
      end
      ST_START: begin
        bus.mat_start = 1'b1;
        rx_drop       = bus.rx_valid;
        state_next    = ST_WAIT;
      end
      ST_WAIT: begin
        rx_drop = bus.rx_valid;
        if (bus.mat_done) state_next = ST_REPORT;
      end
      ST_REPORT: begin
        rx_drop      = bus.rx_valid;
        bus.tx_valid = 1'b1;
        bus.tx_data  = result_byte[byte_idx_reg];
        if (bus.tx_ready && byte_idx_reg == LAST_BYTE) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      elem_idx_reg     <= '0;
      byte_idx_reg     <= '0;
      result_reg       <= '0;
      result_valid_reg <= 1'b0;
      drop_cnt_reg     <= 8'h00;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.rx_valid) elem_idx_reg <= IDX_W'(1);
        end
        ST_LOAD: begin
          if (bus.rx_valid) begin
            elem_idx_reg <= (elem_idx_reg == LAST_ELEM) ? '0 : elem_idx_reg + 1'b1;
          end else if (timeout_hit) begin
            elem_idx_reg <= '0;
          end
        end
        ST_WAIT: begin
          if (bus.mat_done) begin
            result_reg       <= bus.mat_result;
            result_valid_reg <= 1'b1;
            byte_idx_reg     <= '0;
          end
        end
        ST_REPORT: begin
          if (bus.tx_ready) begin
            byte_idx_reg <= (byte_idx_reg == LAST_BYTE) ? '0 : byte_idx_reg + 1'b1;
          end
        end
        default: ;
      endcase
      if (rx_drop && drop_cnt_reg != 8'hFF) drop_cnt_reg <= drop_cnt_reg + 8'd1;
    end
  end

  assign bus.gpio_result = result_reg;
  assign bus.gpio_valid  = result_valid_reg;
  assign bus.drop_cnt    = drop_cnt_reg;

endmodule

// File: tb/tb_matrix_uart_sequencer.sv
// ---------------------------------------------------------------------------
// tb_matrix_uart_sequencer
//
// Purpose: randomized self-checking bench for matrix_uart_sequencer. The
// stimulus side keeps a job-level reference model (list of collected bytes,
// idle-cycle count, drop count) and pushes expected mat_data words and TX
// bytes into queues; a monitor pops and compares whenever the DUT starts the
// core or completes a TX handshake. Builds with or without
// MATRIX_SEQ_TIMEOUT_EN and exercises the matching behaviour.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_matrix_uart_sequencer;
  localparam int N_ELEM      = 4;
  localparam int RESULT_W    = 32;
  localparam int TIMEOUT_CYC = 100;
  localparam int N_BYTES     = RESULT_W / 8;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;
  always #5 sys_clk = ~sys_clk;

  matrix_uart_sequencer_if #(.N_ELEM(N_ELEM), .RESULT_W(RESULT_W)) bus ();

  matrix_uart_sequencer #(
    .N_ELEM      (N_ELEM),
    .RESULT_W    (RESULT_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [8*N_ELEM-1:0] exp_mat_q [$];
  logic [7:0]          exp_tx_q  [$];
  logic [7:0]          cur_job   [$];
  int                  idle_run   = 0;
  int                  drop_exp   = 0;
  int                  err_exp    = 0;
  int                  err_seen   = 0;
  bit                  model_busy = 1'b0;
  int                  job_no     = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // One RX byte; the model either collects it or counts it as dropped.
  task automatic send_byte(input logic [7:0] b);
    logic [8*N_ELEM-1:0] w;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    if (model_busy) begin
      if (drop_exp < 255) drop_exp++;
    end else begin
      cur_job.push_back(b);
      idle_run = 0;
      if (cur_job.size() == N_ELEM) begin
        w = '0;
        for (int i = 0; i < N_ELEM; i++) w[8*i +: 8] = cur_job[i];
        exp_mat_q.push_back(w);
        cur_job.delete();
        model_busy = 1'b1;
      end
    end
    tick();
    bus.rx_valid = 1'b0;
  endtask

  // Idle RX cycles; a partial load older than TIMEOUT_CYC idle cycles is lost.
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      if (!model_busy && cur_job.size() > 0) begin
        idle_run++;
`ifdef MATRIX_SEQ_TIMEOUT_EN
        if (idle_run == TIMEOUT_CYC) begin
          cur_job.delete();
          idle_run = 0;
          err_exp++;
        end
`endif
      end
      tick();
    end
  endtask

  task automatic send_elems(input logic [8*N_ELEM-1:0] elems, input int max_gap);
    for (int i = 0; i < N_ELEM; i++) begin
      if (i > 0) idle($urandom_range(0, max_gap));
      send_byte(elems[8*i +: 8]);
    end
  endtask

  // Called in the cycle right after the final element byte.
  task automatic finish_job(input logic [RESULT_W-1:0] result, input int drops, input bit bp10);
    int first;
    check("mat_start_latency", 64'(bus.mat_start), 64'(1));
    tick();
    check("mat_start_one_cycle", 64'(bus.mat_start), 64'(0));
    for (int d = 0; d < drops; d++) send_byte(8'($urandom));
    check("drop_cnt", 64'(bus.drop_cnt), 64'(drop_exp));
    check("wait_busy", 64'(bus.busy), 64'(1));
    check("wait_no_tx", 64'(bus.tx_valid), 64'(0));
    for (int d = $urandom_range(0, 3); d > 0; d--) tick();
    for (int k = 0; k < N_BYTES; k++) exp_tx_q.push_back(result[8*k +: 8]);
    bus.mat_done   = 1'b1;
    bus.mat_result = result;
    tick();
    bus.mat_done   = 1'b0;
    bus.mat_result = RESULT_W'($urandom);
    check("gpio_result", 64'(bus.gpio_result), 64'(result));
    check("gpio_valid", 64'(bus.gpio_valid), 64'(1));
    check("tx_valid_after_done", 64'(bus.tx_valid), 64'(1));
    first = 0;
    if (bp10) begin
      bus.tx_ready = 1'b0;
      for (int c = 0; c < 10; c++) begin
        check("bp_tx_data", 64'(bus.tx_data), 64'(result[7:0]));
        tick();
      end
      bus.tx_ready = 1'b1;
      tick();
      bus.tx_ready = 1'b0;
      check("bp_next_byte", 64'(bus.tx_data), 64'(result[15:8]));
      first = 1;
    end
    for (int k = first; k < N_BYTES; k++) begin
      for (int s = $urandom_range(0, 2); s > 0; s--) tick();
      bus.tx_ready = 1'b1;
      tick();
      bus.tx_ready = 1'b0;
    end
    check("busy_after_last", 64'(bus.busy), 64'(0));
    model_busy = 1'b0;
    job_no++;
    $display("job %0d result=%h drops=%0d drop_cnt=%0d", job_no, result, drops, bus.drop_cnt);
  endtask

  // Monitor: compares DUT outputs against the queued expectations.
  bit         stall_prev = 1'b0;
  logic [7:0] data_prev  = 8'h00;
  always @(negedge sys_clk) begin
    if (rst_n) begin
      if (bus.mat_start) begin
        if (exp_mat_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mat_start_unexpected actual=1 required=0");
        end else begin
          check("mat_data", 64'(bus.mat_data), 64'(exp_mat_q.pop_front()));
        end
      end
      if (bus.tx_valid && bus.tx_ready) begin
        if (exp_tx_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected actual=%0h required=none", bus.tx_data);
        end else begin
          check("tx_byte", 64'(bus.tx_data), 64'(exp_tx_q.pop_front()));
        end
      end
      if (stall_prev) begin
        check("tx_hold_valid", 64'(bus.tx_valid), 64'(1));
        check("tx_hold_data", 64'(bus.tx_data), 64'(data_prev));
      end
      if (bus.err_timeout) err_seen++;
      stall_prev = bus.tx_valid && !bus.tx_ready;
      data_prev  = bus.tx_data;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, 64'(bus.busy), 64'(0));
    check({tag, "_mat_start"}, 64'(bus.mat_start), 64'(0));
    check({tag, "_tx_valid"}, 64'(bus.tx_valid), 64'(0));
    check({tag, "_err"}, 64'(bus.err_timeout), 64'(0));
    check({tag, "_gpio_valid"}, 64'(bus.gpio_valid), 64'(0));
    check({tag, "_gpio_result"}, 64'(bus.gpio_result), 64'(0));
    check({tag, "_mat_data"}, 64'(bus.mat_data), 64'(0));
    check({tag, "_tx_data"}, 64'(bus.tx_data), 64'(0));
    check({tag, "_drop_cnt"}, 64'(bus.drop_cnt), 64'(0));
  endtask

  initial begin
    bus.rx_valid   = 1'b0;
    bus.rx_data    = 8'h00;
    bus.mat_done   = 1'b0;
    bus.mat_result = '0;
    bus.tx_ready   = 1'b0;
    rst_n          = 1'b0;
    repeat (3) tick();
    check_reset_values("reset");
    rst_n = 1'b1;
    tick();

    // mat_done while idle must be ignored
    bus.mat_done   = 1'b1;
    bus.mat_result = 32'hDEADBEEF;
    tick();
    bus.mat_done   = 1'b0;
    check("idle_done_gpio_valid", 64'(bus.gpio_valid), 64'(0));
    check("idle_done_gpio_result", 64'(bus.gpio_result), 64'(0));
    check("idle_done_busy", 64'(bus.busy), 64'(0));

    // Basic job with 10-cycle TX backpressure on the first byte
    send_elems(32'h04030201, 0);
    finish_job(32'h00000005, 0, 1'b1);

    // Three bytes dropped during WAIT
    send_elems(32'($urandom), 2);
    finish_job(32'($urandom), 3, 1'b0);

    // Randomized jobs
    for (int j = 0; j < 20; j++) begin
      idle($urandom_range(0, 3));
      send_elems(32'($urandom), 4);
      finish_job(32'($urandom), $urandom_range(0, 2), 1'b0);
    end

`ifdef MATRIX_SEQ_TIMEOUT_EN
    // Partial load expires after exactly TIMEOUT_CYC idle cycles
    send_byte(8'h11);
    send_byte(8'h22);
    for (int i = 1; i <= TIMEOUT_CYC; i++) begin
      check("timeout_pulse_cycle", 64'(bus.err_timeout), 64'(i == TIMEOUT_CYC));
      idle(1);
    end
    check("timeout_back_idle", 64'(bus.busy), 64'(0));
    send_elems(32'h04030201, 0);
    finish_job(32'($urandom), 0, 1'b0);
    // A byte in the expiry cycle wins over the timeout
    send_byte(8'hAA);
    for (int i = 0; i < N_ELEM - 1; i++) begin
      idle(TIMEOUT_CYC - 1);
      send_byte(8'hBB + 8'(i));
    end
    finish_job(32'($urandom), 0, 1'b0);
`else
    // Without the timeout LOAD waits forever
    send_byte(8'hA1);
    send_byte(8'hB2);
    idle(10000);
    check("no_timeout_still_busy", 64'(bus.busy), 64'(1));
    send_byte(8'hC3);
    send_byte(8'hD4);
    finish_job(32'($urandom), 0, 1'b0);
`endif

    // 300 drops saturate the counter
    send_elems(32'($urandom), 1);
    finish_job(32'($urandom), 300, 1'b0);
    check("drop_saturated", 64'(bus.drop_cnt), 64'(255));

    // Reset during WAIT, then a stale mat_done
    send_elems(32'($urandom), 1);
    check("pre_reset_start", 64'(bus.mat_start), 64'(1));
    tick();
    rst_n = 1'b0;
    tick();
    rst_n          = 1'b1;
    model_busy     = 1'b0;
    drop_exp       = 0;
    bus.mat_done   = 1'b1;
    bus.mat_result = 32'h00001234;
    tick();
    bus.mat_done   = 1'b0;
    check_reset_values("midreset");
    repeat (3) tick();
    check("midreset_tx_valid_later", 64'(bus.tx_valid), 64'(0));
    check("midreset_gpio_later", 64'(bus.gpio_result), 64'(0));

    // Normal operation resumes after the reset
    send_elems(32'($urandom), 2);
    finish_job(32'($urandom), 1, 1'b0);

    repeat (3) tick();
    check("mat_queue_drained", 64'(exp_mat_q.size()), 64'(0));
    check("tx_queue_drained", 64'(exp_tx_q.size()), 64'(0));
    check("err_timeout_count", 64'(err_seen), 64'(err_exp));
    check("final_drop_cnt", 64'(bus.drop_cnt), 64'(drop_exp));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
